// File: rtl/hw_index_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hw_index_decoder
// Description : Rebuilds a VEC_W-bit vector from a count header beat followed
//               by ascending set-bit index beats, with order/truncation flags.
// Revision    : 1.0 - initial release
// ============================================================================
module hw_index_decoder #(
    parameter int VEC_W   = 1024,
    parameter int IDX_W   = 10,
    parameter int MAX_LOC = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [IDX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_vec,
    output logic [IDX_W-1:0] out_cnt,
    output logic [1:0]       out_err
);

    localparam int               c_REM_W   = $clog2(MAX_LOC + 1);
    localparam logic [c_REM_W-1:0] c_MAX_REM = c_REM_W'(MAX_LOC);
    localparam logic [IDX_W-1:0] c_MAX_IDX = IDX_W'(MAX_LOC);
    localparam logic [c_REM_W-1:0] c_REM_ONE = c_REM_W'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic [VEC_W-1:0]   r_vec;
    logic [IDX_W-1:0]   r_cnt;
    logic [1:0]         r_err;
    logic [c_REM_W-1:0] r_rem;
    logic [IDX_W-1:0]   r_prev;
    logic               r_first;

    logic               w_accept;
    logic               w_hdr;
    logic               w_idx;
    logic               w_trunc;
    logic [c_REM_W-1:0] w_hdr_rem;

    // in_ready is registered so it stays low through reset and the EMIT state
    assign w_accept  = in_valid & r_in_ready;
    assign w_hdr     = w_accept & in_sof & (r_state != S_EMIT);
    assign w_idx     = w_accept & ~in_sof & (r_state == S_COLLECT);
    assign w_trunc   = (in_data > c_MAX_IDX);
    assign w_hdr_rem = w_trunc ? c_MAX_REM : c_REM_W'(in_data);

    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hdr) begin
                    w_state_nxt = (w_hdr_rem == '0) ? S_EMIT : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_hdr) begin
                    w_state_nxt = (w_hdr_rem == '0) ? S_EMIT : S_COLLECT;
                end else if (w_idx && (r_rem == c_REM_ONE)) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_out_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != S_EMIT);
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_rem   <= '0;
            r_prev  <= '0;
            r_first <= 1'b0;
        end else if (w_hdr) begin
            r_vec   <= '0;
            r_cnt   <= in_data;
            r_err   <= {w_trunc, 1'b0};
            r_rem   <= w_hdr_rem;
            r_first <= 1'b1;
        end else if (w_idx) begin
            // Out-of-order or duplicate indices still set their bit
            r_vec[in_data] <= 1'b1;
            r_rem          <= r_rem - c_REM_ONE;
            r_prev         <= in_data;
            r_first        <= 1'b0;
            if (!r_first && (in_data <= r_prev)) begin
                r_err[0] <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_vec   = r_vec;
    assign out_cnt   = r_cnt;
    assign out_err   = r_err;

endmodule
`default_nettype wire
